// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-file geometry, scoreboard width
// and the instruction word loaded into a pipeline register to squash it.
package pipe_pkg;

  localparam int REG_AW = 5;
  localparam int NREG   = 32;
  localparam int SB_W   = 2;

  // sll $0,$0,0 -- the canonical MIPS NOP loaded on flush/bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pc_stall_ctrl_if.sv
// Signals between the pipeline datapath (master) and the stall/flush
// controller (slave): ID operands, WB write port, branch redirect, and
// the register write-enables / squash controls going back.
interface pc_stall_ctrl_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int PW   = 32
);

  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_we;
  logic [AW-1:0] id_rd;
  logic          wb_we;
  logic [AW-1:0] wb_rd;
  logic          br_taken;

  logic            pc_wt;
  logic            ifid_wt;
  logic            ifid_flush;
  logic            idex_bubble;
  logic [NREG-1:0] busy_o;
  logic [PW-1:0]   stall_cnt;
  logic [PW-1:0]   flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_rd,
    output wb_we, wb_rd, br_taken,
    input  pc_wt, ifid_wt, ifid_flush, idex_bubble, busy_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_rd,
    input  wb_we, wb_rd, br_taken,
    output pc_wt, ifid_wt, ifid_flush, idex_bubble, busy_o, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pc_stall_ctrl_sb_cnt.sv
// One scoreboard entry: counts writes to a single register that have
// issued but not yet reached WB. Saturates at both ends so an illegal
// extra inc/dec cannot wrap the count and corrupt later hazard checks.
module sb_cnt
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  output logic [SB_W-1:0] cnt,
  output logic            busy
);

  // Up/down count of in-flight writers; simultaneous inc and dec cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != '1)) begin
      cnt <= cnt + SB_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - SB_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pc_stall_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline without
// forwarding. Holds PC and IF/ID while the ID instruction reads a
// register with a write still in flight; a taken branch in EX overrides
// the stall, squashes IF/ID and ID/EX and lets the PC load the target.
module pc_stall_ctrl #(
  parameter int NREG = pipe_pkg::NREG,
  parameter int AW   = pipe_pkg::REG_AW,
  parameter int PW   = 32
) (
  input logic           clk,
  input logic           rst,
  pc_stall_ctrl_if.slave bus
);

  import pipe_pkg::*;

  logic [SB_W-1:0] pend [NREG];
  logic [NREG-1:0] busy;
  logic [SB_W-1:0] rs_cnt;
  logic [SB_W-1:0] rt_cnt;
  logic            rs_wb;
  logic            rt_wb;
  logic            hit_rs;
  logic            hit_rt;
  logic            stall;
  logic            issue;

  // Register 0 is hardwired zero, so it never has a pending writer
  assign pend[0] = '0;
  assign busy[0] = 1'b0;

  // One saturating pending-write counter per real register
  for (genvar r = 1; r < NREG; r++) begin : g_sb
    logic inc;
    logic dec;
    assign inc = issue && bus.id_we && (bus.id_rd == AW'(r));
    assign dec = bus.wb_we && (bus.wb_rd == AW'(r));
    sb_cnt u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc),
      .dec  (dec),
      .cnt  (pend[r]),
      .busy (busy[r])
    );
  end

  // Look up the pending counts of both ID source registers
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (bus.id_rs == AW'(r)) rs_cnt = pend[r];
      if (bus.id_rt == AW'(r)) rt_cnt = pend[r];
    end
  end

  // The register file writes in the first half-cycle, so a writer that
  // is in WB right now no longer blocks the reader.
  assign rs_wb  = bus.wb_we && (bus.wb_rd == bus.id_rs);
  assign rt_wb  = bus.wb_we && (bus.wb_rd == bus.id_rt);
  assign hit_rs = (bus.id_rs != '0) && ((rs_cnt - SB_W'(rs_wb)) != '0);
  assign hit_rt = (bus.id_rt != '0) && ((rt_cnt - SB_W'(rt_wb)) != '0);

  assign stall = bus.id_valid && !bus.br_taken &&
                 ((bus.id_use_rs && hit_rs) || (bus.id_use_rt && hit_rt));
  assign issue = bus.id_valid && !stall && !bus.br_taken;

  assign bus.pc_wt       = !stall;
  assign bus.ifid_wt     = !stall;
  assign bus.ifid_flush  = bus.br_taken;
  assign bus.idex_bubble = stall || bus.br_taken;
  assign bus.busy_o      = busy;

  // Saturating performance counters for stall and flush cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (stall && (bus.stall_cnt != '1)) bus.stall_cnt <= bus.stall_cnt + PW'(1);
      if (bus.br_taken && (bus.flush_cnt != '1)) bus.flush_cnt <= bus.flush_cnt + PW'(1);
    end
  end

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Directed testbench for pc_stall_ctrl: hazard stalls, WB bypass, WAW
// tracking, branch priority, register 0 and reset during a stall.
module tb_pc_stall_ctrl;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  pc_stall_ctrl_if #(.NREG(32), .AW(5), .PW(32)) sif ();

  pc_stall_ctrl #(.NREG(32), .AW(5), .PW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent pending-count model used only to flag illegal stimulus
  int   m_pend [32];
  logic m_hit_rs;
  logic m_hit_rt;
  logic m_stall;
  logic m_issue;
  logic m_inc;
  logic m_dec;

  // Assert that the stimulus never over- or underflows a scoreboard entry
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      m_hit_rs = (sif.id_rs != 0) &&
                 ((m_pend[sif.id_rs] - ((sif.wb_we && sif.wb_rd == sif.id_rs) ? 1 : 0)) != 0);
      m_hit_rt = (sif.id_rt != 0) &&
                 ((m_pend[sif.id_rt] - ((sif.wb_we && sif.wb_rd == sif.id_rt) ? 1 : 0)) != 0);
      m_stall  = sif.id_valid && !sif.br_taken &&
                 ((sif.id_use_rs && m_hit_rs) || (sif.id_use_rt && m_hit_rt));
      m_issue  = sif.id_valid && !m_stall && !sif.br_taken;
      for (int r = 1; r < 32; r++) begin
        m_inc = m_issue && sif.id_we && (sif.id_rd == 5'(r));
        m_dec = sif.wb_we && (sif.wb_rd == 5'(r));
        if (m_inc && !m_dec) begin
          if (m_pend[r] == 3) $error("[TB] scoreboard overflow on reg %0d", r);
          else m_pend[r] = m_pend[r] + 1;
        end else if (m_dec && !m_inc) begin
          if (m_pend[r] == 0) $error("[TB] scoreboard underflow on reg %0d", r);
          else m_pend[r] = m_pend[r] - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic we,
                          input logic [4:0] rd);
    sif.id_valid  = v;
    sif.id_rs     = rs;
    sif.id_rt     = rt;
    sif.id_use_rs = urs;
    sif.id_use_rt = urt;
    sif.id_we     = we;
    sif.id_rd     = rd;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] rd);
    sif.wb_we = we;
    sif.wb_rd = rd;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    drive_wb(1'b0, 5'd0);
    sif.br_taken = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    vec_cnt++;
    if (sif.busy_o !== 32'h0) begin
      err_cnt++; $display("[TB] FAIL reset_busy: got %h want %h", sif.busy_o, 32'h0);
    end
    vec_cnt++;
    if (sif.stall_cnt !== 32'd0 || sif.flush_cnt !== 32'd0) begin
      err_cnt++; $display("[TB] FAIL reset_cnts: got %0d/%0d want 0/0", sif.stall_cnt, sif.flush_cnt);
    end
    vec_cnt++;
    if ({sif.pc_wt, sif.ifid_wt, sif.ifid_flush, sif.idex_bubble} !== 4'b1100) begin
      err_cnt++; $display("[TB] FAIL reset_ctrl: got %b want %b",
                          {sif.pc_wt, sif.ifid_wt, sif.ifid_flush, sif.idex_bubble}, 4'b1100);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    // producer writes $8
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8);
    tick();
    // consumer reads $8: stall while producer is in EX and MEM
    drive_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int c = 0; c < 2; c++) begin
      #2;
      vec_cnt++;
      if ({sif.pc_wt, sif.ifid_wt, sif.idex_bubble} !== 3'b001) begin
        err_cnt++; $display("[TB] FAIL load_use_stall%0d: got %b want %b", c,
                            {sif.pc_wt, sif.ifid_wt, sif.idex_bubble}, 3'b001);
      end
      tick();
    end
    // producer now in WB: consumer proceeds
    drive_wb(1'b1, 5'd8);
    #2;
    vec_cnt++;
    if ({sif.pc_wt, sif.idex_bubble} !== 2'b10) begin
      err_cnt++; $display("[TB] FAIL load_use_release: got %b want %b",
                          {sif.pc_wt, sif.idex_bubble}, 2'b10);
    end
    tick();
    idle();
    vec_cnt++;
    if (sif.stall_cnt !== 32'd2) begin
      err_cnt++; $display("[TB] FAIL load_use_stall_cnt: got %0d want %0d", sif.stall_cnt, 2);
    end
    vec_cnt++;
    if (sif.busy_o[8] !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL load_use_busy8: got %b want %b", sif.busy_o[8], 1'b0);
    end
  endtask

  task automatic test_wb_bypass();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    vec_cnt++;
    if (sif.busy_o[9] !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL bypass_busy9_set: got %b want %b", sif.busy_o[9], 1'b1);
    end
    drive_id(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0);
    drive_wb(1'b1, 5'd9);
    #2;
    vec_cnt++;
    if (sif.pc_wt !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL bypass_no_stall: got %b want %b", sif.pc_wt, 1'b1);
    end
    tick();
    idle();
    vec_cnt++;
    if (sif.busy_o[9] !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL bypass_busy9_clr: got %b want %b", sif.busy_o[9], 1'b0);
    end
  endtask

  task automatic test_distance2();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    drive_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #2;
    vec_cnt++;
    if (sif.pc_wt !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL dist2_stall: got %b want %b", sif.pc_wt, 1'b0);
    end
    tick();
    drive_wb(1'b1, 5'd7);
    #2;
    vec_cnt++;
    if (sif.pc_wt !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL dist2_release: got %b want %b", sif.pc_wt, 1'b1);
    end
    tick();
    idle();
    vec_cnt++;
    if (sif.stall_cnt !== 32'd3) begin
      err_cnt++; $display("[TB] FAIL dist2_stall_cnt: got %0d want %0d", sif.stall_cnt, 3);
    end
  endtask

  task automatic test_waw();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    tick();
    tick();
    idle();
    vec_cnt++;
    if (sif.busy_o[5] !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL waw_busy_two: got %b want %b", sif.busy_o[5], 1'b1);
    end
    // first WB while reading $5: one writer still outstanding -> stall
    drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    drive_wb(1'b1, 5'd5);
    #2;
    vec_cnt++;
    if (sif.pc_wt !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL waw_stall_first_wb: got %b want %b", sif.pc_wt, 1'b0);
    end
    tick();
    vec_cnt++;
    if (sif.busy_o[5] !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL waw_busy_after_wb1: got %b want %b", sif.busy_o[5], 1'b1);
    end
    // second WB: reader proceeds
    #1;
    vec_cnt++;
    if (sif.pc_wt !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL waw_release: got %b want %b", sif.pc_wt, 1'b1);
    end
    tick();
    idle();
    vec_cnt++;
    if (sif.busy_o[5] !== 1'b0 || sif.stall_cnt !== 32'd4) begin
      err_cnt++; $display("[TB] FAIL waw_final: got busy5=%b cnt=%0d want busy5=0 cnt=4",
                          sif.busy_o[5], sif.stall_cnt);
    end
  endtask

  task automatic test_branch();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    drive_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4);
    #2;
    vec_cnt++;
    if (sif.pc_wt !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL branch_pre_stall: got %b want %b", sif.pc_wt, 1'b0);
    end
    tick();
    sif.br_taken = 1'b1;
    #2;
    vec_cnt++;
    if ({sif.pc_wt, sif.ifid_wt, sif.ifid_flush, sif.idex_bubble} !== 4'b1111) begin
      err_cnt++; $display("[TB] FAIL branch_ctrl: got %b want %b",
                          {sif.pc_wt, sif.ifid_wt, sif.ifid_flush, sif.idex_bubble}, 4'b1111);
    end
    tick();
    idle();
    vec_cnt++;
    if (sif.busy_o[4] !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL branch_busy4: got %b want %b", sif.busy_o[4], 1'b0);
    end
    vec_cnt++;
    if (sif.flush_cnt !== 32'd1 || sif.stall_cnt !== 32'd5) begin
      err_cnt++; $display("[TB] FAIL branch_cnts: got flush=%0d stall=%0d want flush=1 stall=5",
                          sif.flush_cnt, sif.stall_cnt);
    end
    drive_wb(1'b1, 5'd3);
    tick();
    idle();
    vec_cnt++;
    if (sif.busy_o !== 32'h0) begin
      err_cnt++; $display("[TB] FAIL branch_cleanup: got %h want %h", sif.busy_o, 32'h0);
    end
  endtask

  task automatic test_reg0();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0);
    drive_wb(1'b1, 5'd0);
    #2;
    vec_cnt++;
    if (sif.pc_wt !== 1'b1 || sif.busy_o[0] !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL reg0_no_stall: got pc_wt=%b busy0=%b want 1/0",
                          sif.pc_wt, sif.busy_o[0]);
    end
    tick();
    idle();
    vec_cnt++;
    if (sif.busy_o !== 32'h0) begin
      err_cnt++; $display("[TB] FAIL reg0_busy: got %h want %h", sif.busy_o, 32'h0);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10);
    tick();
    drive_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #2;
    vec_cnt++;
    if (sif.pc_wt !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL rst_mid_pre: got %b want %b", sif.pc_wt, 1'b0);
    end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (sif.pc_wt !== 1'b1 || sif.busy_o !== 32'h0) begin
      err_cnt++; $display("[TB] FAIL rst_mid_clear: got pc_wt=%b busy=%h want 1/0",
                          sif.pc_wt, sif.busy_o);
    end
    vec_cnt++;
    if (sif.stall_cnt !== 32'd0 || sif.flush_cnt !== 32'd0) begin
      err_cnt++; $display("[TB] FAIL rst_mid_cnts: got %0d/%0d want 0/0", sif.stall_cnt, sif.flush_cnt);
    end
    idle();
    tick();
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (sif.pc_wt !== 1'b1 || sif.busy_o !== 32'h0 || sif.stall_cnt !== 32'd0) begin
      err_cnt++; $display("[TB] FAIL rst_mid_after: got pc_wt=%b busy=%h cnt=%0d want 1/0/0",
                          sif.pc_wt, sif.busy_o, sif.stall_cnt);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_wb_bypass();
    test_distance2();
    test_waw();
    test_branch();
    test_reg0();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
